// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// A value is accepted over a valid/ready handshake, converted over BIN_W cycles
// and then held on the output side until the consumer takes it.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   bin_in carries a value
//   in_ready   converter can take a value this cycle
//   bin_in     unsigned binary input
//   out_valid  bcd_out/ovf/blank carry a result
//   out_ready  consumer takes the result
//   bcd_out    packed BCD, units digit in [3:0]
//   ovf        input did not fit in DIGITS decimal digits
//   blank      per-digit leading-zero mask for display drivers (bit 0 always 0)
module bin_to_bcd_seq #(
   parameter int unsigned BIN_W  = 12,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf,
   output logic [DIGITS-1:0]     blank
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned SrW  = BcdW + BIN_W;
   localparam int unsigned CntW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e              state_q;
   logic [SrW-1:0]      sr_q;
   logic [CntW-1:0]     cnt_q;
   logic                ovf_acc_q;
   logic                out_valid_q;
   logic [BcdW-1:0]     bcd_q;
   logic                ovf_q;

   logic [SrW-1:0]      sr_adj;
   logic [SrW-1:0]      sr_shl;
   logic                top_bit;
   logic                accept;

   // Combinational ready so a result can be released and a new value taken on one edge.
   assign in_ready = !rst && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
   assign accept   = in_valid && in_ready;

   // Add-3 correction on every BCD nibble in parallel; the BCD field sits above the
   // binary field so a single left shift moves the next binary bit into digit 0.
   always_comb begin
      sr_adj = sr_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
            sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
         end
      end
   end

   assign sr_shl  = {sr_adj[SrW-2:0], 1'b0};
   // A bit leaving the top digit is a carry worth 10^DIGITS.
   assign top_bit = sr_adj[SrW-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sr_q        <= '0;
         cnt_q       <= '0;
         ovf_acc_q   <= 1'b0;
         out_valid_q <= 1'b0;
         bcd_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  sr_q      <= {{BcdW{1'b0}}, bin_in};
                  cnt_q     <= CntW'(BIN_W);
                  ovf_acc_q <= 1'b0;
                  state_q   <= StShift;
               end
            end
            StShift: begin
               sr_q      <= sr_shl;
               ovf_acc_q <= ovf_acc_q | top_bit;
               cnt_q     <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
                  bcd_q       <= sr_shl[SrW-1 -: BcdW];
                  ovf_q       <= ovf_acc_q | top_bit;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (accept) begin
                     sr_q      <= {{BcdW{1'b0}}, bin_in};
                     cnt_q     <= CntW'(BIN_W);
                     ovf_acc_q <= 1'b0;
                     state_q   <= StShift;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign bcd_out   = bcd_q;
   assign ovf       = ovf_q;

   // Digit i is a leading zero when it and every digit above it are zero.
   // An overflowed value has hidden upper digits, so nothing is blanked.
   always_comb begin
      blank = '0;
      for (int i = 1; i < int'(DIGITS); i++) begin
         blank[i] = !ovf_q && ((bcd_q >> (4*i)) == '0);
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance 0: BIN_W=12 DIGITS=4; 1: BIN_W=12 DIGITS=3; 2: BIN_W=6 DIGITS=2
   logic [2:0]  in_valid_v;
   logic [2:0]  in_ready_v;
   logic [2:0]  out_valid_v;
   logic [2:0]  out_ready_v;
   logic [2:0]  ovf_v;
   logic [11:0] bin_in_v [3];
   logic [15:0] bcd_v    [3];
   logic [3:0]  blank_v  [3];

   logic [15:0] bcd_a;
   logic [11:0] bcd_b;
   logic [7:0]  bcd_c;
   logic [3:0]  blank_a;
   logic [2:0]  blank_b;
   logic [1:0]  blank_c;

   assign bcd_v[0]   = bcd_a;
   assign bcd_v[1]   = {4'b0, bcd_b};
   assign bcd_v[2]   = {8'b0, bcd_c};
   assign blank_v[0] = blank_a;
   assign blank_v[1] = {1'b0, blank_b};
   assign blank_v[2] = {2'b0, blank_c};

   bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .bin_in(bin_in_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .bcd_out(bcd_a), .ovf(ovf_v[0]), .blank(blank_a));

   bin_to_bcd_seq #(.BIN_W(12), .DIGITS(3)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .bin_in(bin_in_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .bcd_out(bcd_b), .ovf(ovf_v[1]), .blank(blank_b));

   bin_to_bcd_seq #(.BIN_W(6), .DIGITS(2)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .bin_in(bin_in_v[2][5:0]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
      .bcd_out(bcd_c), .ovf(ovf_v[2]), .blank(blank_c));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: decimal digits by plain division, blanking from magnitude.
   function automatic void model(input longint unsigned v, input int d,
                                 output logic [15:0] bcd, output logic o,
                                 output logic [3:0] bl);
      longint unsigned p = 1;
      longint unsigned m;
      for (int i = 0; i < d; i++) p = p * 10;
      o   = (v >= p);
      m   = v % p;
      bcd = '0;
      bl  = '0;
      p   = 1;
      for (int i = 0; i < d; i++) begin
         bcd[4*i +: 4] = 4'((m / p) % 10);
         if (i > 0) bl[i] = !o && (m < p);
         p = p * 10;
      end
   endfunction

   // Drives one transaction on instance s and returns what came out and after how many edges.
   task automatic convert(input int s, input int unsigned v, output logic [15:0] bcd,
                          output logic o, output logic [3:0] bl, output int lat);
      lat = -1;
      in_valid_v[s] = 1'b1;
      bin_in_v[s]   = 12'(v);
      @(posedge clk); #1;
      in_valid_v[s] = 1'b0;
      bin_in_v[s]   = 12'($urandom);
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (out_valid_v[s]) begin
            lat = k;
            break;
         end
      end
      bcd = bcd_v[s];
      o   = ovf_v[s];
      bl  = blank_v[s];
      out_ready_v[s] = 1'b1;
      @(posedge clk); #1;
      out_ready_v[s] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid_v = '0;
      out_ready_v = '0;
      for (int s = 0; s < 3; s++) bin_in_v[s] = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready_v !== 3'b000) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 000", in_ready_v);
      end
      n_checks++;
      if (out_valid_v !== 3'b000) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 000", out_valid_v);
      end
      n_checks++;
      if (ovf_v !== 3'b000) begin
         n_fail++; $display("FAIL reset_ovf: got %b expected 000", ovf_v);
      end
      n_checks++;
      if (bcd_v[0] !== 16'h0 || bcd_v[1] !== 16'h0 || bcd_v[2] !== 16'h0) begin
         n_fail++; $display("FAIL reset_bcd: got %h %h %h expected 0", bcd_v[0], bcd_v[1], bcd_v[2]);
      end
      n_checks++;
      if (blank_v[0] !== 4'b1110 || blank_v[1] !== 4'b0110 || blank_v[2] !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_blank: got %b %b %b expected 1110 0110 0010",
                  blank_v[0], blank_v[1], blank_v[2]);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready_v !== 3'b111) begin
         n_fail++; $display("FAIL release_in_ready: got %b expected 111", in_ready_v);
      end
   endtask

   task automatic test_basic;
      logic [15:0] b; logic o; logic [3:0] l; int lat;
      convert(0, 4095, b, o, l, lat);
      n_checks++;
      if (lat !== 12) begin n_fail++; $display("FAIL basic_latency: got %0d expected 12", lat); end
      n_checks++;
      if (b !== 16'h4095 || o !== 1'b0 || l !== 4'b0000) begin
         n_fail++; $display("FAIL basic_4095: got %h ovf %b blank %b expected 4095 0 0000", b, o, l);
      end
   endtask

   task automatic test_blanking;
      int unsigned vals [3] = '{0, 59, 1000};
      logic [15:0] exp_b [3] = '{16'h0000, 16'h0059, 16'h1000};
      logic [3:0]  exp_l [3] = '{4'b1110, 4'b1100, 4'b0000};
      logic [15:0] b; logic o; logic [3:0] l; int lat;
      for (int i = 0; i < 3; i++) begin
         convert(0, vals[i], b, o, l, lat);
         n_checks++;
         if (b !== exp_b[i] || l !== exp_l[i] || o !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_%0d: got %h ovf %b blank %b expected %h 0 %b",
                     vals[i], b, o, l, exp_b[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_overflow;
      logic [15:0] b; logic o; logic [3:0] l; int lat;
      convert(1, 1234, b, o, l, lat);
      n_checks++;
      if (b !== 16'h0234 || o !== 1'b1 || l !== 4'b0000) begin
         n_fail++; $display("FAIL ovf_1234: got %h ovf %b blank %b expected 234 1 000", b, o, l);
      end
      convert(1, 999, b, o, l, lat);
      n_checks++;
      if (b !== 16'h0999 || o !== 1'b0 || l !== 4'b0000) begin
         n_fail++; $display("FAIL ovf_999: got %h ovf %b blank %b expected 999 0 000", b, o, l);
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] b0; logic o0; logic [3:0] l0; int lat; int gap;
      in_valid_v[0] = 1'b1;
      bin_in_v[0]   = 12'd777;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      n_checks++;
      if (in_ready_v[0] !== 1'b0) begin
         n_fail++; $display("FAIL shift_in_ready: got %b expected 0", in_ready_v[0]);
      end
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (out_valid_v[0]) begin lat = k; break; end
      end
      n_checks++;
      if (lat !== 12 || bcd_v[0] !== 16'h0777) begin
         n_fail++; $display("FAIL bp_result: got lat %0d %h expected 12 0777", lat, bcd_v[0]);
      end
      b0 = bcd_v[0]; o0 = ovf_v[0]; l0 = blank_v[0];
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid_v[0] !== 1'b1 || bcd_v[0] !== b0 || ovf_v[0] !== o0 ||
             blank_v[0] !== l0 || in_ready_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got v%b %h o%b l%b r%b expected v1 %h o%b l%b r0", k,
                     out_valid_v[0], bcd_v[0], ovf_v[0], blank_v[0], in_ready_v[0], b0, o0, l0);
         end
      end
      out_ready_v[0] = 1'b1;
      in_valid_v[0]  = 1'b1;
      bin_in_v[0]    = 12'd31;
      #1;
      n_checks++;
      if (in_ready_v[0] !== 1'b1) begin
         n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready_v[0]);
      end
      @(posedge clk); #1;
      out_ready_v[0] = 1'b0;
      in_valid_v[0]  = 1'b0;
      bin_in_v[0]    = 12'd4000;
      gap = 0;
      for (int k = 0; k < 100; k++) begin
         if (out_valid_v[0]) break;
         gap++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (gap !== 12) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 12", gap); end
      n_checks++;
      if (bcd_v[0] !== 16'h0031 || blank_v[0] !== 4'b1100) begin
         n_fail++; $display("FAIL b2b_31: got %h blank %b expected 0031 1100", bcd_v[0], blank_v[0]);
      end
      out_ready_v[0] = 1'b1;
      @(posedge clk); #1;
      out_ready_v[0] = 1'b0;
   endtask

   task automatic test_mid_reset;
      logic [15:0] b; logic o; logic [3:0] l; int lat;
      in_valid_v[0] = 1'b1;
      bin_in_v[0]   = 12'd2024;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid_v[0] !== 1'b0 || bcd_v[0] !== 16'h0 || ovf_v[0] !== 1'b0 ||
          in_ready_v[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_state: got v%b %h o%b r%b expected v0 0000 o0 r0",
                  out_valid_v[0], bcd_v[0], ovf_v[0], in_ready_v[0]);
      end
      rst = 1'b0;
      #1;
      convert(0, 2024, b, o, l, lat);
      n_checks++;
      if (b !== 16'h2024 || o !== 1'b0 || lat !== 12) begin
         n_fail++; $display("FAIL midrst_2024: got %h ovf %b lat %0d expected 2024 0 12", b, o, lat);
      end
   endtask

   task automatic test_random;
      logic [15:0] b, eb; logic o, eo; logic [3:0] l, el; int lat; int unsigned v;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 15; i++) begin
            v = $urandom_range(0, 4095);
            convert(s, v, b, o, l, lat);
            model(64'(v), 4 - s, eb, eo, el);
            n_checks++;
            if (b !== eb || o !== eo || l !== el || lat !== 12) begin
               n_fail++;
               $display("FAIL rand_s%0d_%0d: got %h o%b l%b lat%0d expected %h o%b l%b lat12",
                        s, v, b, o, l, lat, eb, eo, el);
            end
         end
      end
   endtask

   task automatic test_sweep;
      logic [15:0] b, eb; logic o, eo; logic [3:0] l, el; int lat;
      for (int v = 0; v < 64; v++) begin
         convert(2, v, b, o, l, lat);
         model(64'(v), 2, eb, eo, el);
         n_checks++;
         if (b !== eb || o !== 1'b0 || l !== el || lat !== 6) begin
            n_fail++;
            $display("FAIL sweep_%0d: got %h o%b l%b lat%0d expected %h o0 l%b lat6",
                     v, b, o, l, lat, eb, el);
         end
      end
   endtask

   task automatic test_back_to_back;
      int unsigned vals [5];
      int acc_idx = 0;
      int res_idx = 0;
      int last = -1;
      logic acc;
      logic [15:0] eb; logic eo; logic [3:0] el;
      for (int i = 0; i < 5; i++) vals[i] = $urandom_range(0, 63);
      out_ready_v[2] = 1'b1;
      in_valid_v[2]  = 1'b1;
      bin_in_v[2]    = 12'(vals[0]);
      for (int cyc = 0; cyc < 200 && res_idx < 5; cyc++) begin
         acc = in_valid_v[2] && in_ready_v[2];
         @(posedge clk); #1;
         if (acc) begin
            acc_idx++;
            if (acc_idx < 5) bin_in_v[2] = 12'(vals[acc_idx]);
            else in_valid_v[2] = 1'b0;
         end
         if (out_valid_v[2]) begin
            model(64'(vals[res_idx]), 2, eb, eo, el);
            n_checks++;
            if (bcd_v[2] !== eb || blank_v[2] !== el || ovf_v[2] !== eo) begin
               n_fail++;
               $display("FAIL tput_val_%0d: got %h l%b o%b expected %h l%b o%b", res_idx,
                        bcd_v[2], blank_v[2], ovf_v[2], eb, el, eo);
            end
            if (res_idx > 0) begin
               n_checks++;
               if (cyc - last !== 7) begin
                  n_fail++; $display("FAIL tput_period_%0d: got %0d expected 7", res_idx, cyc - last);
               end
            end
            last = cyc;
            res_idx++;
         end
      end
      n_checks++;
      if (res_idx !== 5) begin
         n_fail++; $display("FAIL tput_count: got %0d expected 5", res_idx);
      end
      out_ready_v[2] = 1'b0;
      in_valid_v[2]  = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blanking();
      test_overflow();
      test_backpressure();
      test_mid_reset();
      test_random();
      test_sweep();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
